load_extend_unit: RTL and testbench

- Pipelined load-data alignment and sign/zero extension unit for the memory-writeback path; parametrised successor to the single-width sign extender.
- Takes a raw XLEN-wide memory word, a byte offset and a RISC-V load funct3, and selects the addressed byte/half/word/double.
- Sign- or zero-extends the selected field to XLEN and flags misaligned or illegal accesses.
- Results are buffered in a 2-entry skid FIFO with valid/ready handshakes on both sides.

---
 rtl/load_extend_unit.sv | 104 ++++++++++
 tb/tb_load_extend_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_extend_unit.sv
// Load-data alignment and sign/zero extension for the writeback path.
// A combinational extractor feeds a 2-entry FIFO with valid/ready on both sides.
module load_extend_unit #(
  parameter int XLEN             = 32,
  parameter int OFFS_W           = $clog2(XLEN/8),
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_data,
  input  logic [OFFS_W-1:0] in_offset,
  input  logic [2:0]        in_funct3,
  input  logic              in_extend_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_err
);

  localparam int NBYTES = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] res_data;
  logic            res_err;
  logic            field_msb;
  logic            sign_bit;
  logic            illegal;
  logic            misaligned;
  logic            overrun;
  int              fbytes;
  int              fbits;

  always_comb begin
    shifted = in_data >> {in_offset, 3'b000};
    fbytes  = 1 << in_funct3[1:0];
    fbits   = fbytes * 8;

    case (in_funct3[1:0])
      2'b00:   field_msb = shifted[7];
      2'b01:   field_msb = shifted[15];
      2'b10:   field_msb = shifted[31];
      default: field_msb = shifted[XLEN-1];
    endcase
    sign_bit = field_msb & ~in_funct3[2];

    ext_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      ext_data[i] = (i < fbits) ? shifted[i] : sign_bit;
    end

    illegal    = (in_funct3 == 3'b111) ||
                 ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
    misaligned = ((int'(in_offset) & (fbytes - 1)) != 0);
    overrun    = (int'(in_offset) + fbytes) > NBYTES;

    res_err  = 1'b0;
    res_data = in_data;
    if (in_extend_en) begin
      // Misaligned fields are only tolerated when enabled and still inside the word.
      res_err  = illegal || (misaligned && (!ALLOW_MISALIGNED || overrun));
      res_data = res_err ? '0 : ext_data;
    end
  end

  logic [XLEN:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_err, out_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {res_err, res_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed and random stimulus for two load_extend_unit instances (32-bit strict, 64-bit misaligned-tolerant).
module tb_load_extend_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v32 = 0, r32, e32 = 1, ov32, ordy32 = 1, oe32;
  logic [31:0] d32 = 0, od32;
  logic [1:0]  o32 = 0;
  logic [2:0]  f32 = 0;

  logic        v64 = 0, r64, e64 = 1, ov64, ordy64 = 1, oe64;
  logic [63:0] d64 = 0, od64;
  logic [2:0]  o64 = 0;
  logic [2:0]  f64 = 0;

  load_extend_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_data(d32),
    .in_offset(o32), .in_funct3(f32), .in_extend_en(e32), .out_valid(ov32),
    .out_ready(ordy32), .out_data(od32), .out_err(oe32));

  load_extend_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in_data(d64),
    .in_offset(o64), .in_funct3(f64), .in_extend_en(e64), .out_valid(ov64),
    .out_ready(ordy64), .out_data(od64), .out_err(oe64));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out32 = 0;
  logic [64:0] q32[$];
  logic [64:0] q64[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop: compared on the negedge before the consuming posedge.
  always @(negedge clk) begin
    if (rst_n && ov32 && ordy32) begin
      n_out32++;
      if (q32.size() == 0) check("out32_unexpected", {oe32, 32'd0, od32}, 65'h1_DEAD_BEEF_DEAD_BEEF);
      else check("out32", {oe32, 32'd0, od32}, q32.pop_front());
    end
    if (rst_n && ov64 && ordy64) begin
      if (q64.size() == 0) check("out64_unexpected", {oe64, od64}, 65'h1_DEAD_BEEF_DEAD_BEEF);
      else check("out64", {oe64, od64}, q64.pop_front());
    end
  end

  function automatic logic [64:0] ref_model(input int xlen, input bit allow, input logic [63:0] d,
                                            input int off, input logic [2:0] f3, input bit en);
    int sz;
    logic [63:0] f, r;
    if (!en) return {1'b0, d};
    case (f3[1:0])
      2'b00:   sz = 1;
      2'b01:   sz = 2;
      2'b10:   sz = 4;
      default: sz = 8;
    endcase
    if (f3 == 3'b111 || (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110))) return {1'b1, 64'd0};
    if ((off % sz) != 0 && (!allow || off + sz > xlen / 8)) return {1'b1, 64'd0};
    f = d >> (8 * off);
    case (sz)
      1:       r = f3[2] ? {56'd0, f[7:0]}  : {{56{f[7]}}, f[7:0]};
      2:       r = f3[2] ? {48'd0, f[15:0]} : {{48{f[15]}}, f[15:0]};
      4:       r = f3[2] ? {32'd0, f[31:0]} : {{32{f[31]}}, f[31:0]};
      default: r = f;
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return {1'b0, r};
  endfunction

  // Called right after a posedge; returns right after the posedge that accepts the request.
  task automatic send(input bit sel64, input logic [63:0] d, input int off, input logic [2:0] f3,
                      input bit en, input logic [64:0] exp);
    int waited = 0;
    bit acc = 0;
    if (sel64) begin
      d64 = d; o64 = off[2:0]; f64 = f3; e64 = en; v64 = 1;
    end else begin
      d32 = d[31:0]; o32 = off[1:0]; f32 = f3; e32 = en; v32 = 1;
    end
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = sel64 ? r64 : r32;
      if (!acc) waited++;
    end
    if (acc) begin
      if (sel64) q64.push_back(exp); else q32.push_back(exp);
    end else begin
      check("accept_timeout", 65'd0, 65'd1);
    end
    @(posedge clk); #1;
    v32 = 0; v64 = 0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((q32.size() != 0 || q64.size() != 0) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", 65'(q32.size() + q64.size()), 65'd0);
  endtask

  localparam logic [63:0] W32 = 64'h0000_0000_8070_F0A5;
  localparam logic [63:0] W64 = 64'hFEDC_BA98_7654_3210;

  initial begin
    int t0;
    logic [63:0] rd;
    int ro;
    logic [2:0] rf;
    bit re;

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", 65'(ov32), 65'd0);
    check("rst_in_ready", 65'(r32), 65'd1);
    check("rst_out_data", {oe32, 32'd0, od32}, 65'd0);
    check("rst64_state", {ov64, r64, oe64, od64[61:0]}, {3'b010, 62'd0});
    @(posedge clk); #1;

    send(0, W32, 0, 3'b000, 1, {1'b0, 64'hFFFF_FFA5});
    send(0, W32, 0, 3'b100, 1, {1'b0, 64'h0000_00A5});
    send(0, W32, 2, 3'b001, 1, {1'b0, 64'hFFFF_8070});
    send(0, W32, 1, 3'b001, 1, {1'b1, 64'd0});
    send(0, W32, 0, 3'b011, 1, {1'b1, 64'd0});
    send(0, W32, 0, 3'b111, 1, {1'b1, 64'd0});
    send(0, W32, 0, 3'b110, 1, {1'b1, 64'd0});
    send(0, W32, 0, 3'b010, 1, {1'b0, 64'h8070_F0A5});
    send(0, W32, 2, 3'b101, 1, {1'b0, 64'h0000_8070});
    send(0, W32, 3, 3'b000, 1, {1'b0, 64'hFFFF_FF80});
    send(0, W32, 1, 3'b100, 1, {1'b0, 64'h0000_00F0});
    send(0, W32, 3, 3'b111, 0, {1'b0, W32});
    send(0, W32, 1, 3'b010, 0, {1'b0, W32});

    send(1, W64, 4, 3'b010, 1, {1'b0, 64'hFFFF_FFFF_FEDC_BA98});
    send(1, W64, 4, 3'b110, 1, {1'b0, 64'h0000_0000_FEDC_BA98});
    send(1, W64, 0, 3'b011, 1, {1'b0, W64});
    send(1, W64, 1, 3'b001, 1, {1'b0, 64'h0000_0000_0000_5432});
    send(1, W64, 3, 3'b010, 1, {1'b0, 64'hFFFF_FFFF_DCBA_9876});
    send(1, W64, 6, 3'b010, 1, {1'b1, 64'd0});
    send(1, W64, 4, 3'b011, 1, {1'b1, 64'd0});
    send(1, W64, 0, 3'b111, 1, {1'b1, 64'd0});
    drain();

    // Backpressure: two accepts fill the FIFO, the third request must wait.
    ordy32 = 0;
    send(0, 64'h0000_0000_1234_5678, 0, 3'b000, 1, {1'b0, 64'h0000_0078});
    send(0, 64'h0000_0000_1234_5678, 2, 3'b001, 1, {1'b0, 64'h0000_1234});
    d32 = 32'hCAFE_0081; o32 = 0; f32 = 3'b000; e32 = 1; v32 = 1;
    @(negedge clk);
    check("bp_in_ready_low", 65'(r32), 65'd0);
    check("bp_head_stable", {oe32, 32'd0, od32}, {1'b0, 64'h0000_0078});
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_held", 65'(r32), 65'd0);
    check("bp_head_held", {oe32, 32'd0, od32}, {1'b0, 64'h0000_0078});
    @(posedge clk); #1;
    ordy32 = 1;
    send(0, 64'h0000_0000_CAFE_0081, 0, 3'b000, 1, {1'b0, 64'hFFFF_FF81});
    drain();

    // Streaming at full rate on the 32-bit unit.
    n_out32 = 0;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      rd = {32'd0, 32'($urandom)};
      ro = $urandom_range(0, 3);
      rf = 3'($urandom_range(0, 7));
      re = ($urandom_range(0, 7) != 0);
      send(0, rd, ro, rf, re, ref_model(32, 0, rd, ro, rf, re));
    end
    check("stream_cycles", 65'(cyc - t0), 65'd100);
    drain();
    check("stream_outputs", 65'(n_out32), 65'd100);

    for (int i = 0; i < 60; i++) begin
      rd = {32'($urandom), 32'($urandom)};
      ro = $urandom_range(0, 7);
      rf = 3'($urandom_range(0, 7));
      re = ($urandom_range(0, 7) != 0);
      send(1, rd, ro, rf, re, ref_model(64, 1, rd, ro, rf, re));
    end
    drain();

    // Reset with the FIFO full discards both entries.
    ordy32 = 0;
    send(0, W32, 0, 3'b000, 1, {1'b0, 64'hFFFF_FFA5});
    send(0, W32, 0, 3'b010, 1, {1'b0, 64'h8070_F0A5});
    rst_n = 0;
    q32.delete();
    q64.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("mid_rst_out_valid", 65'(ov32), 65'd0);
    check("mid_rst_in_ready", 65'(r32), 65'd1);
    check("mid_rst_out_data", {oe32, 32'd0, od32}, 65'd0);
    @(posedge clk); #1;
    ordy32 = 1;
    send(0, W32, 2, 3'b001, 1, {1'b0, 64'hFFFF_8070});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
